// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// The default configuration detects overlapping 1011.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  // Width able to hold every length from 0 to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam logic [31:0] DEF_PATTERN_C = 32'b1011;
  localparam int          DEF_LEN_C     = 4;
  localparam bit          DEF_OVERLAP_C = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// clr takes priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// one-cycle registered match pulse and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               sequence_in,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state_out
);

  localparam logic [LEN_W-1:0] RESET_LEN =
    (DEF_LEN > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(DEF_LEN);
  localparam state_t RESET_STATE = (DEF_LEN > 0) ? FILL : IDLE;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (int'(len) > MAX_LEN) ? LEN_W'(MAX_LEN) : len;
  endfunction

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_d;
  logic               detector_q;
  state_t             state_q;
  state_t             state_d;

  // The newest bit sits in position 0; the top bit only matters for the mask.
  logic [MAX_LEN:0]   window;
  logic [MAX_LEN:0]   mask;
  logic               window_full;
  logic               match;

  assign window = {hist_q, sequence_in};

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and synthesis never infers a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i <= MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign window_full = (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q});
  assign match = in_valid && !cfg_load && (len_q != '0) && window_full &&
                 ((window & mask) == ({1'b0, pattern_q} & mask));

  assign fill_inc = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
  assign fill_d   = (match && !overlap_q) ? '0 : fill_inc;

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (clamp_len(cfg_len) == '0) ? IDLE : FILL;
    end else if (in_valid) begin
      if (len_q == '0) begin
        state_d = IDLE;
      end else if (({1'b0, fill_d} + 1'b1) < {1'b0, len_q}) begin
        state_d = FILL;
      end else begin
        state_d = HUNT;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q  <= DEF_PATTERN;
      len_q      <= RESET_LEN;
      overlap_q  <= DEF_OVERLAP;
      hist_q     <= '0;
      fill_q     <= '0;
      detector_q <= 1'b0;
    end else if (cfg_load) begin
      pattern_q  <= cfg_pattern;
      len_q      <= clamp_len(cfg_len);
      overlap_q  <= cfg_overlap;
      hist_q     <= '0;
      fill_q     <= '0;
      detector_q <= 1'b0;
    end else begin
      detector_q <= match;
      if (in_valid) begin
        hist_q <= window[MAX_LEN-1:0];
        fill_q <= fill_d;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_counter (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (cfg_load),
    .cnt   (match_count)
  );

  assign detector_out = detector_q;
  assign state_out    = state_q;

endmodule
